// File: rtl/hazard_scoreboard.sv
// In-flight write scoreboard for the pipelined cpu: picks a forwarding source per
// operand or stalls issue, with load-use latency, flush and saturating perf counters.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic [REG_ADDR_W-1:0]        issue_rs1,
  input  logic [REG_ADDR_W-1:0]        issue_rs2,
  input  logic                         issue_rs1_used,
  input  logic                         issue_rs2_used,
  input  logic [REG_ADDR_W-1:0]        issue_rd,
  input  logic                         issue_regwrite,
  input  logic                         issue_is_load,
  input  logic                         flush,
  output logic                         stall,
  output logic                         issue_accept,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs1,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs2,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_count,
  output logic [CNT_W-1:0]             stall_count,
  output logic [CNT_W-1:0]             hazard_count
);

  localparam int SEL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             hazard;
    logic [SEL_W-1:0] sel;
  } lookup_t;

  logic [DEPTH:1]          valid_q, valid_d;
  logic [DEPTH:1]          load_q, load_d;
  logic [REG_ADDR_W-1:0]   rd_q [1:DEPTH];
  logic [REG_ADDR_W-1:0]   rd_d [1:DEPTH];
  logic [SEL_W-1:0]        count_q, count_d;
  logic                    stall_q;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]        hazard_cnt_q, hazard_cnt_d;
  lookup_t                 lk1, lk2;

  // Oldest-to-youngest scan so the youngest match overwrites older ones.
  function automatic lookup_t lookup(input logic used, input logic [REG_ADDR_W-1:0] rs);
    lookup_t r;
    r = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && (rs != '0) && valid_q[k] && (rd_q[k] == rs)) begin
        r.hazard = (FWD_EN == 0) || (load_q[k] && (k < LOAD_READY));
        r.sel    = SEL_W'(k);
      end
    end
    if ((FWD_EN == 0) || r.hazard) r.sel = '0;
    return r;
  endfunction

  always_comb begin
    lk1          = lookup(issue_rs1_used, issue_rs1);
    lk2          = lookup(issue_rs2_used, issue_rs2);
    stall        = issue_valid & ~flush & (lk1.hazard | lk2.hazard);
    issue_accept = issue_valid & ~flush & ~stall;
    fwd_sel_rs1  = stall ? '0 : lk1.sel;
    fwd_sel_rs2  = stall ? '0 : lk2.sel;
  end

  always_comb begin
    valid_d = '0;
    load_d  = '0;
    for (int k = 1; k <= DEPTH; k++) rd_d[k] = '0;
    count_d = '0;
    if (!flush) begin
      valid_d[1]       = issue_accept & issue_regwrite & (issue_rd != '0);
      valid_d[DEPTH:2] = valid_q[DEPTH-1:1];
    end
    load_d[1]       = issue_is_load;
    load_d[DEPTH:2] = load_q[DEPTH-1:1];
    rd_d[1]         = issue_rd;
    for (int k = 2; k <= DEPTH; k++) rd_d[k] = rd_q[k-1];
    for (int k = 1; k <= DEPTH; k++) count_d = count_d + SEL_W'(valid_d[k]);
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    hazard_cnt_d = hazard_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (stall && !stall_q && (hazard_cnt_q != '1)) hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      load_q       <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
      count_q      <= '0;
      stall_q      <= 1'b0;
      stall_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      load_q       <= load_d;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
      count_q      <= count_d;
      stall_q      <= stall;
      stall_cnt_q  <= stall_cnt_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign inflight_count = count_q;
  assign stall_count    = stall_cnt_q;
  assign hazard_count   = hazard_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a stall-only instance
// share stimulus; directed scenarios plus random traffic against a queue model.
module tb_hazard_scoreboard;
  localparam int D  = 3;
  localparam int LR = 2;

  logic clock = 1'b0;
  logic reset;
  logic issue_valid, issue_rs1_used, issue_rs2_used, issue_regwrite, issue_is_load, issue_flush;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;

  logic f_stall, f_acc, n_stall, n_acc;
  logic [1:0] f_s1, f_s2, f_inf, n_s1, n_s2, n_inf;
  logic [15:0] f_sc, f_hc, n_sc, n_hc;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(D), .FWD_EN(1), .LOAD_READY(LR), .CNT_W(16)) u_fwd (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
    .flush(issue_flush), .stall(f_stall), .issue_accept(f_acc),
    .fwd_sel_rs1(f_s1), .fwd_sel_rs2(f_s2), .inflight_count(f_inf),
    .stall_count(f_sc), .hazard_count(f_hc));

  hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(D), .FWD_EN(0), .LOAD_READY(LR), .CNT_W(16)) u_nofwd (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
    .flush(issue_flush), .stall(n_stall), .issue_accept(n_acc),
    .fwd_sel_rs1(n_s1), .fwd_sel_rs2(n_s2), .inflight_count(n_inf),
    .stall_count(n_sc), .hazard_count(n_hc));

  // Reference model: per instance, a history of issued writers, newest at index 0 (age 1).
  typedef struct packed {bit v; bit [4:0] rd; bit ld;} ent_t;
  ent_t hq_f[$];
  ent_t hq_n[$];
  int sc_f, hc_f, sc_n, hc_n;
  bit pst_f, pst_n;

  function automatic void model_clear();
    hq_f.delete(); hq_n.delete();
    sc_f = 0; hc_f = 0; sc_n = 0; hc_n = 0; pst_f = 0; pst_n = 0;
  endfunction

  function automatic void op_eval(input ent_t q[$], input bit fwd_en, input bit used,
                                  input bit [4:0] rs, output bit h, output int s);
    bit rdy;
    h = 0; s = 0;
    if (!used || rs == 0) return;
    foreach (q[i]) begin
      if (q[i].v && q[i].rd == rs) begin
        rdy = !q[i].ld || (i + 1) >= LR;
        h = fwd_en ? !rdy : 1'b1;
        s = (fwd_en && rdy) ? i + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic void model_eval(input ent_t q[$], input bit fwd_en, output bit st,
                                     output bit acc, output int s1, output int s2);
    bit h1, h2, iv, fl;
    iv = (issue_valid === 1'b1);
    fl = (issue_flush === 1'b1);
    op_eval(q, fwd_en, issue_rs1_used === 1'b1, issue_rs1, h1, s1);
    op_eval(q, fwd_en, issue_rs2_used === 1'b1, issue_rs2, h2, s2);
    st  = iv && !fl && (h1 || h2);
    acc = iv && !fl && !st;
    if (st) begin s1 = 0; s2 = 0; end
  endfunction

  function automatic int live(input ent_t q[$]);
    int c = 0;
    foreach (q[i]) if (q[i].v) c++;
    return c;
  endfunction

  // One clock edge; the model advances with the same inputs the DUTs sampled.
  task automatic step();
    bit stf, af, stn, an;
    int a, b;
    ent_t e;
    model_eval(hq_f, 1'b1, stf, af, a, b);
    model_eval(hq_n, 1'b0, stn, an, a, b);
    @(posedge clock);
    if (!reset) begin
      model_clear();
    end else begin
      if (issue_flush) begin
        hq_f.delete(); hq_n.delete();
      end else begin
        e = '{v: af && issue_regwrite && issue_rd != 0, rd: issue_rd, ld: issue_is_load};
        hq_f.push_front(e);
        if (hq_f.size() > D) void'(hq_f.pop_back());
        e.v = an && issue_regwrite && issue_rd != 0;
        hq_n.push_front(e);
        if (hq_n.size() > D) void'(hq_n.pop_back());
      end
      if (stf) begin
        if (sc_f < 65535) sc_f++;
        if (!pst_f && hc_f < 65535) hc_f++;
      end
      if (stn) begin
        if (sc_n < 65535) sc_n++;
        if (!pst_n && hc_n < 65535) hc_n++;
      end
      pst_f = stf; pst_n = stn;
    end
    @(negedge clock);
  endtask

  task automatic set_issue(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2, input logic [4:0] d,
                           input logic w, input logic l);
    issue_valid = v; issue_rs1 = r1; issue_rs1_used = u1; issue_rs2 = r2; issue_rs2_used = u2;
    issue_rd = d; issue_regwrite = w; issue_is_load = l; issue_flush = 1'b0;
  endtask

  task automatic idle();
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_clear();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    issue_valid = 1'b1;
    #1;
    total++; if (f_stall !== 1'b0 || f_inf !== 2'd0 || f_sc !== 16'd0) $display("FAIL rst_state: stall=%b inf=%0d sc=%0d want 0/0/0", f_stall, f_inf, f_sc); else passed++;
    total++; if (f_acc !== 1'b1) $display("FAIL rst_accept: got %b want 1", f_acc); else passed++;
    issue_valid = 1'b0;
    reset = 1'b1;
    step();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_stall !== 1'b1 || n_stall !== 1'b1) $display("FAIL rst_pre_stall: f=%b n=%b want 1/1", f_stall, n_stall); else passed++;
    step();
    #1;
    total++; if (f_sc !== 16'd1 || n_stall !== 1'b1) $display("FAIL rst_pre_count: f_sc=%0d n_stall=%b want 1/1", f_sc, n_stall); else passed++;
    reset = 1'b0;
    model_clear();
    #1;
    total++; if (n_stall !== 1'b0) $display("FAIL rst_mid_stall: got %b want 0", n_stall); else passed++;
    total++; if (n_sc !== 16'd0 || f_sc !== 16'd0 || n_hc !== 16'd0 || f_hc !== 16'd0) $display("FAIL rst_counters: n_sc=%0d f_sc=%0d n_hc=%0d f_hc=%0d want 0", n_sc, f_sc, n_hc, f_hc); else passed++;
    total++; if (n_inf !== 2'd0 || f_inf !== 2'd0) $display("FAIL rst_inflight: n=%0d f=%0d want 0", n_inf, f_inf); else passed++;
    total++; if (n_acc !== 1'b1) $display("FAIL rst_mid_accept: got %b want 1", n_acc); else passed++;
    reset = 1'b1;
    step();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    #1;
    total++; if (f_inf !== 2'd1 || n_inf !== 2'd1) $display("FAIL rst_resume: f_inf=%0d n_inf=%0d want 1", f_inf, n_inf); else passed++;
  endtask

  task automatic test_forward();
    do_reset();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    set_issue(1'b1, 5'd5, 1'b1, 5'bxxxxx, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_stall !== 1'b0 || f_acc !== 1'b1) $display("FAIL fwd1_stall: stall=%b acc=%b want 0/1", f_stall, f_acc); else passed++;
    total++; if (f_s1 !== 2'd1 || f_s2 !== 2'd0) $display("FAIL fwd1_sel: s1=%0d s2=%0d want 1/0", f_s1, f_s2); else passed++;
    total++; if (n_stall !== 1'b1 || n_s1 !== 2'd0) $display("FAIL nofwd1_stall: stall=%b s1=%0d want 1/0", n_stall, n_s1); else passed++;
    step();
    set_issue(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_s2 !== 2'd2 || f_stall !== 1'b0) $display("FAIL fwd2_sel: s2=%0d stall=%b want 2/0", f_s2, f_stall); else passed++;
    total++; if (n_stall !== 1'b1) $display("FAIL nofwd2_stall: got %b want 1", n_stall); else passed++;
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_stall !== 1'b1 || f_s1 !== 2'd0 || f_acc !== 1'b0) $display("FAIL lu_stall: stall=%b s1=%0d acc=%b want 1/0/0", f_stall, f_s1, f_acc); else passed++;
    step();
    #1;
    total++; if (f_stall !== 1'b0 || f_s1 !== 2'd2 || f_acc !== 1'b1) $display("FAIL lu_fwd: stall=%b s1=%0d acc=%b want 0/2/1", f_stall, f_s1, f_acc); else passed++;
    step();
    idle();
    #1;
    total++; if (f_sc !== 16'd1 || f_hc !== 16'd1) $display("FAIL lu_counts: sc=%0d hc=%0d want 1/1", f_sc, f_hc); else passed++;
    total++; if (n_sc !== 16'd2 || n_hc !== 16'd1) $display("FAIL lu_counts_nofwd: sc=%0d hc=%0d want 2/1", n_sc, n_hc); else passed++;
    step();
  endtask

  task automatic test_nofwd();
    do_reset();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    set_issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (n_stall !== 1'b1) $display("FAIL nf_stall_c%0d: got %b want 1", c, n_stall); else passed++;
      total++; if (f_s1 !== 2'(c) || f_stall !== 1'b0) $display("FAIL nf_fwd_age_c%0d: s1=%0d stall=%b want %0d/0", c, f_s1, f_stall, c); else passed++;
      step();
    end
    #1;
    total++; if (n_stall !== 1'b0 || n_acc !== 1'b1 || n_s1 !== 2'd0) $display("FAIL nf_release: stall=%b acc=%b s1=%0d want 0/1/0", n_stall, n_acc, n_s1); else passed++;
    total++; if (f_s1 !== 2'd0) $display("FAIL nf_retired: s1=%0d want 0", f_s1); else passed++;
    step();
    idle();
    #1;
    total++; if (n_sc !== 16'd3 || n_hc !== 16'd1 || f_sc !== 16'd0) $display("FAIL nf_counts: n_sc=%0d n_hc=%0d f_sc=%0d want 3/1/0", n_sc, n_hc, f_sc); else passed++;
    step();
  endtask

  task automatic test_youngest();
    do_reset();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    step();
    set_issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_s1 !== 2'd1 || f_s2 !== 2'd1 || f_stall !== 1'b0) $display("FAIL young_sel: s1=%0d s2=%0d stall=%b want 1/1/0", f_s1, f_s2, f_stall); else passed++;
    step();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    set_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_stall !== 1'b0 || f_s1 !== 2'd0 || f_s2 !== 2'd0) $display("FAIL x0_fwd: stall=%b s1=%0d s2=%0d want 0/0/0", f_stall, f_s1, f_s2); else passed++;
    total++; if (n_stall !== 1'b0 || n_acc !== 1'b1) $display("FAIL x0_nofwd: stall=%b acc=%b want 0/1", n_stall, n_acc); else passed++;
    step();
  endtask

  task automatic test_flush();
    do_reset();
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (f_stall !== 1'b1) $display("FAIL fl_pre: got %b want 1", f_stall); else passed++;
    issue_flush = 1'b1;
    #1;
    total++; if (f_stall !== 1'b0 || f_acc !== 1'b0 || n_stall !== 1'b0 || n_acc !== 1'b0) $display("FAIL fl_cycle: f=%b/%b n=%b/%b want 0/0 0/0", f_stall, f_acc, n_stall, n_acc); else passed++;
    step();
    issue_flush = 1'b0;
    #1;
    total++; if (f_inf !== 2'd0 || n_inf !== 2'd0) $display("FAIL fl_inflight: f=%0d n=%0d want 0", f_inf, n_inf); else passed++;
    total++; if (f_acc !== 1'b1 || f_s1 !== 2'd0 || n_acc !== 1'b1) $display("FAIL fl_reissue: f_acc=%b s1=%0d n_acc=%b want 1/0/1", f_acc, f_s1, n_acc); else passed++;
    total++; if (f_sc !== 16'd0 || f_hc !== 16'd0) $display("FAIL fl_counts: sc=%0d hc=%0d want 0/0", f_sc, f_hc); else passed++;
    step();
  endtask

  task automatic test_random();
    bit stf, af, stn, an;
    int a1, a2, b1, b2;
    logic [39:0] obs, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_rs1      = 5'($urandom_range(0, 4));
      issue_rs2      = 5'($urandom_range(0, 4));
      issue_rs1_used = 1'($urandom_range(0, 1));
      issue_rs2_used = 1'($urandom_range(0, 1));
      issue_rd       = 5'($urandom_range(0, 4));
      issue_regwrite = ($urandom_range(0, 3) != 0);
      issue_is_load  = ($urandom_range(0, 2) == 0);
      issue_flush    = ($urandom_range(0, 31) == 0);
      #1;
      model_eval(hq_f, 1'b1, stf, af, a1, a2);
      model_eval(hq_n, 1'b0, stn, an, b1, b2);
      obs = {f_stall, f_acc, f_s1, f_s2, f_inf, f_sc, f_hc};
      exp = {stf, af, 2'(a1), 2'(a2), 2'(live(hq_f)), 16'(sc_f), 16'(hc_f)};
      total++; if (obs !== exp) $display("FAIL rand_fwd c%0d: got %h want %h", c, obs, exp); else passed++;
      obs = {n_stall, n_acc, n_s1, n_s2, n_inf, n_sc, n_hc};
      exp = {stn, an, 2'(b1), 2'(b2), 2'(live(hq_n)), 16'(sc_n), 16'(hc_n)};
      total++; if (obs !== exp) $display("FAIL rand_nofwd c%0d: got %h want %h", c, obs, exp); else passed++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    model_clear();
    idle();
    @(negedge clock);
    test_reset();
    test_forward();
    test_load_use();
    test_nofwd();
    test_youngest();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard detection and forwarding-select unit for the pipelined cpu. It replaces the single prev_rd/prev_RegWrite comparison with a DEPTH-entry in-flight scoreboard that tracks every pending register write. For each operand it either picks a forwarding source or stalls issue. It also supports a load-use latency, a stall-only mode, a pipeline flush, and saturating hazard/stall counters for the bench.

Parameters:
REG_ADDR_W, 5, register address width (x0 is hardwired zero).
DEPTH, 3, number of in-flight stages tracked after issue (stage 1 = youngest, stage DEPTH = retiring); DEPTH >= 2.
FWD_EN, 1, 1 = forward when data is ready; 0 = stall on any in-flight match.
LOAD_READY, 2, first stage at which a load result can be forwarded; 1 <= LOAD_READY <= DEPTH.
CNT_W, 16, width of the performance counters.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
issue_valid  in  1  decode stage presents an instruction.
issue_rs1  in  REG_ADDR_W  source register 1.
issue_rs2  in  REG_ADDR_W  source register 2.
issue_rs1_used  in  1  rs1 is actually read.
issue_rs2_used  in  1  rs2 is actually read.
issue_rd  in  REG_ADDR_W  destination register.
issue_regwrite  in  1  instruction writes rd.
issue_is_load  in  1  instruction is a load.
flush  in  1  kill all in-flight entries and the current issue.
stall  out  1  hold PC/decode this cycle (combinational).
issue_accept  out  1  issue_valid & ~stall & ~flush (combinational).
fwd_sel_rs1  out  $clog2(DEPTH+1)  0 = register file, k = forward from stage k.
fwd_sel_rs2  out  $clog2(DEPTH+1)  same as fwd_sel_rs1, for rs2.
inflight_count  out  $clog2(DEPTH+1)  number of valid entries (registered).
stall_count  out  CNT_W  cycles with stall=1, saturating.
hazard_count  out  CNT_W  distinct stall episodes, saturating.

Behaviour:
- Entry k holds {valid, rd, is_load}. On every rising edge, entry k+1 <= entry k and entry DEPTH retires.
- Entry 1 <= accepted issue if issue_regwrite=1 and issue_rd!=0; otherwise entry 1 <= bubble (valid=0). A stall therefore inserts a bubble while older entries keep advancing.
- Retire semantics: the register file is written at the end of the cycle in which an entry sits in stage DEPTH. Stage DEPTH is still matched in that cycle; the next cycle the register file holds the value.
- Match condition for an operand: *_used=1, rs!=0, and entry valid with matching rd. With several matches, the youngest (lowest k) wins.
- Readiness: a non-load entry is ready at any k>=1; a load entry is ready only when k>=LOAD_READY.
- FWD_EN=1: a ready youngest match gives fwd_sel=k. A not-ready youngest match raises stall. No match gives fwd_sel=0.
- FWD_EN=0: any match raises stall; fwd_sel is always 0.
- stall = issue_valid & ~flush & (hazard on rs1 | hazard on rs2). While stall=1, fwd_sel outputs are don't-care but are driven 0.
- Flush: stall=0 and issue_accept=0 that cycle. All entries are invalid after the edge and the counters are unaffected.
- stall_q is a register holding the previous stall. stall_count increments when stall=1; hazard_count increments when stall=1 & stall_q=0. Both hold at all-ones.
- Reset (async, reset=0, legal mid-stall): all entries invalid, stall_q=0, counters=0, inflight_count=0. Combinational outputs follow from the cleared state: stall=0, fwd_sel=0, and issue_accept follows issue_valid & ~flush.
- No X propagation: unused rs fields must not affect outputs.

Test Plan:
- Reset mid-stall (load x6 then use x6, reset=0 during the stall cycle) -> stall=0, counters=0, inflight_count=0 immediately; normal issue resumes on the first edge after reset=1.
- FWD_EN=1: add x5 accepted, next cycle rs1=x5 -> stall=0, fwd_sel_rs1=1. One cycle later rs2=x5 -> fwd_sel_rs2=2.
- FWD_EN=1, LOAD_READY=2: load x6, next cycle rs1=x6 -> stall=1 for exactly 1 cycle, then fwd_sel_rs1=2. Result: stall_count=1, hazard_count=1.
- FWD_EN=0, DEPTH=3: write x7, next cycle rs1=x7 -> stall for 3 cycles, then accepted with fwd_sel_rs1=0. Result: stall_count=3, hazard_count=1.
- Producers rd=x5 at stages 1 and 2, consumer rs1=x5 -> fwd_sel_rs1=1. Producer rd=x0 with consumer rs1=x0 -> stall=0, fwd_sel=0.
- Flush asserted during a load-use stall -> stall=0 and issue_accept=0 that cycle; inflight_count=0 next cycle; the reissued consumer is accepted with fwd_sel=0.
